// File: rtl/task1_sched_pkg.sv
// Shared types and sizing helpers for the task1 round-robin scheduler.
package task1_sched_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_N       = 4;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Timer must reach TIMEOUT-1; keep at least one bit when timeout is disabled.
    function automatic int tmr_w(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/task1_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr wins.
module rr_arbiter
    import task1_sched_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/task1_sched.sv
// Shares one task1 engine among N requesters; one operation in flight,
// round-robin grant, optional response timeout, sticky stray-result flag.
module task1_sched
    import task1_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N       = DEF_N,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N*WIDTH-1:0] req_a,
    input  logic [N*WIDTH-1:0] req_b,
    input  logic [N*WIDTH-1:0] req_c,
    input  logic [N*WIDTH-1:0] req_d,
    output logic [N-1:0]       rsp_valid,
    output logic [WIDTH-1:0]   rsp_q,
    output logic               rsp_timeout,
    output logic               eng_in_val,
    output logic [WIDTH-1:0]   eng_a,
    output logic [WIDTH-1:0]   eng_b,
    output logic [WIDTH-1:0]   eng_c,
    output logic [WIDTH-1:0]   eng_d,
    input  logic [WIDTH-1:0]   eng_q,
    input  logic               eng_out_val,
    output logic               busy,
    output logic               err_stray
);

    localparam int IW = idx_w(N);
    localparam int TW = tmr_w(TIMEOUT);
    localparam logic [TW-1:0] TMR_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] TMR_MAX  = '1;

    state_t           r_state, w_next;
    logic [IW-1:0]    r_ptr, r_owner;
    logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
    logic [WIDTH-1:0] r_q;
    logic             r_to;
    logic [TW-1:0]    r_tmr;
    logic             r_stray;

    logic [N-1:0]     w_grant;
    logic [IW-1:0]    w_gidx;
    logic             w_any;
    logic             w_hs;
    logic             w_expire;
    logic [N-1:0]     w_own_oh;

    rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    assign w_hs     = (r_state == IDLE) && w_any;
    assign w_expire = (TIMEOUT != 0) && (r_tmr == TMR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            // A result arriving on the expiry cycle is still a normal result.
            WAIT:    if (eng_out_val || w_expire) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operands and owner are captured only on the handshake cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else if (w_hs) begin
            r_a     <= req_a[w_gidx*WIDTH +: WIDTH];
            r_b     <= req_b[w_gidx*WIDTH +: WIDTH];
            r_c     <= req_c[w_gidx*WIDTH +: WIDTH];
            r_d     <= req_d[w_gidx*WIDTH +: WIDTH];
            r_owner <= w_gidx;
            r_ptr   <= (w_gidx == IW'(N - 1)) ? '0 : w_gidx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmr <= '0;
        end else if (r_state == ISSUE) begin
            r_tmr <= '0;
        end else if (r_state == WAIT && !eng_out_val && r_tmr != TMR_MAX) begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q  <= '0;
            r_to <= 1'b0;
        end else if (r_state == WAIT) begin
            if (eng_out_val) begin
                r_q  <= eng_q;
                r_to <= 1'b0;
            end else if (w_expire) begin
                r_q  <= '0;
                r_to <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               r_stray <= 1'b0;
        else if (eng_out_val && r_state != WAIT) r_stray <= 1'b1;
    end

    always_comb begin
        w_own_oh          = '0;
        w_own_oh[r_owner] = 1'b1;
    end

    assign req_ready   = (r_state == IDLE) ? w_grant : '0;
    assign eng_in_val  = (r_state == ISSUE);
    assign rsp_valid   = (r_state == RESP) ? w_own_oh : '0;
    assign rsp_q       = (r_state == RESP) ? r_q : '0;
    assign rsp_timeout = (r_state == RESP) && r_to;
    assign eng_a       = r_a;
    assign eng_b       = r_b;
    assign eng_c       = r_c;
    assign eng_d       = r_d;
    assign busy        = (r_state != IDLE);
    assign err_stray   = r_stray;

endmodule

// File: tb/tb_task1_sched.sv
// Directed bench for task1_sched with a stub engine of programmable latency.
module tb_task1_sched;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_q;
    logic             rsp_timeout;
    logic             eng_in_val;
    logic [W-1:0]     eng_a, eng_b, eng_c, eng_d;
    logic [W-1:0]     eng_q;
    logic             eng_out_val;
    logic             busy;
    logic             err_stray;

    int checks = 0;
    int errors = 0;

    task1_sched #(.WIDTH(W), .N(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_c       (req_c),
        .req_d       (req_d),
        .rsp_valid   (rsp_valid),
        .rsp_q       (rsp_q),
        .rsp_timeout (rsp_timeout),
        .eng_in_val  (eng_in_val),
        .eng_a       (eng_a),
        .eng_b       (eng_b),
        .eng_c       (eng_c),
        .eng_d       (eng_d),
        .eng_q       (eng_q),
        .eng_out_val (eng_out_val),
        .busy        (busy),
        .err_stray   (err_stray)
    );

    always #5 clk = ~clk;

    // Stub engine: Q = a*b + c - d, out_val L cycles after in_val.
    int               stub_L    = 2;
    bit               stub_mute = 1'b0;
    logic             stray     = 1'b0;
    logic             stub_ov;
    logic [W-1:0]     stub_q;
    int               stub_cnt;
    logic [W-1:0]     sa, sb, sc, sd;

    function automatic logic [W-1:0] eng_f(input logic signed [W-1:0] a, b, c, d);
        return a * b + c - d;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_ov  <= 1'b0;
            stub_q   <= '0;
            stub_cnt <= 0;
            sa <= '0; sb <= '0; sc <= '0; sd <= '0;
        end else begin
            stub_ov <= 1'b0;
            if (eng_in_val) begin
                sa <= eng_a; sb <= eng_b; sc <= eng_c; sd <= eng_d;
                if (stub_L <= 1) begin
                    stub_ov <= !stub_mute;
                    stub_q  <= eng_f(eng_a, eng_b, eng_c, eng_d);
                end else begin
                    stub_cnt <= stub_L - 1;
                end
            end else if (stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1 && !stub_mute) begin
                    stub_ov <= 1'b1;
                    stub_q  <= eng_f(sa, sb, sc, sd);
                end
            end
        end
    end

    assign eng_out_val = stub_ov | stray;
    assign eng_q       = stub_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after the handshake edge; k counts negedges until rsp_valid.
    task automatic wait_rsp(output int k, output int pulses, output bit overlap,
                            output logic [W-1:0] ea, eb, ec, ed);
        k = 0; pulses = 0; overlap = 1'b0;
        ea = '0; eb = '0; ec = '0; ed = '0;
        do begin
            @(negedge clk);
            k++;
            if (eng_in_val) begin
                pulses++;
                ea = eng_a; eb = eng_b; ec = eng_c; ed = eng_d;
            end
            if (req_ready != '0) overlap = 1'b1;
        end while (rsp_valid == '0 && k < 200);
    endtask

    task automatic op(input string tag, input int idx,
                      input logic [W-1:0] a, b, c, d,
                      input int L, input bit mute,
                      input logic [N-1:0] exp_grant,
                      input logic [W-1:0] exp_q, input bit exp_to, input int exp_k);
        int k, pulses;
        bit overlap;
        logic [W-1:0] ea, eb, ec, ed;
        @(negedge clk);
        stub_L = L;
        stub_mute = mute;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_c[idx*W +: W] = c;
        req_d[idx*W +: W] = d;
        #1;
        chk({tag, ".grant"}, 32'(req_ready), 32'(exp_grant));
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_rsp(k, pulses, overlap, ea, eb, ec, ed);
        chk({tag, ".latency"}, 32'(k), 32'(exp_k));
        chk({tag, ".inval_pulses"}, 32'(pulses), 32'd1);
        chk({tag, ".no_overlap"}, 32'(overlap), 32'd0);
        chk({tag, ".eng_ops"}, {ea, eb}, {a, b});
        chk({tag, ".eng_ops_cd"}, {ec, ed}, {c, d});
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(exp_grant));
        chk({tag, ".rsp_q"}, 32'(rsp_q), 32'(exp_q));
        chk({tag, ".rsp_timeout"}, 32'(rsp_timeout), 32'(exp_to));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, pulses, seen;
        bit overlap;
        logic [W-1:0] ea, eb, ec, ed;
        logic [N-1:0] oh;
        logic [W-1:0] q3 [4];
        q3[0] = 16'd3; q3[1] = 16'd6; q3[2] = 16'd9; q3[3] = 16'd12;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_q", 32'(rsp_q), 32'd0);
        chk("rst.rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst.eng_in_val", 32'(eng_in_val), 32'd0);
        chk("rst.eng_a", 32'(eng_a), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.err_stray", 32'(err_stray), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single requests: 10*2+1-3=18, -5*2+3-1=-8, 1*1+1-1=1 (moves pointer to 0)
        op("t1", 0, 16'd10, 16'd2, 16'd1, 16'd3, 3, 1'b0, 4'b0001, 16'h0012, 1'b0, 5);
        op("t2", 2, 16'hFFFB, 16'd2, 16'd3, 16'd1, 1, 1'b0, 4'b0100, 16'hFFF8, 1'b0, 3);
        op("t2b", 3, 16'd1, 16'd1, 16'd1, 16'd1, 2, 1'b0, 4'b1000, 16'h0001, 1'b0, 4);

        // All four requesting continuously: strict rotation 0,1,2,3,0,1,2,3
        @(negedge clk);
        stub_L = 2;
        stub_mute = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(i + 1);
            req_b[i*W +: W] = 16'd3;
            req_c[i*W +: W] = 16'd0;
            req_d[i*W +: W] = 16'd0;
        end
        req_valid = '1;
        #1;
        for (int n = 0; n < 8; n++) begin
            int waitc;
            waitc = 0;
            while (req_ready == '0 && waitc < 10) begin
                @(negedge clk);
                #1;
                waitc++;
            end
            oh = 4'b0001 << (n % 4);
            chk($sformatf("t3.grant%0d", n), 32'(req_ready), 32'(oh));
            @(posedge clk);
            #1;
            if (n == 7) req_valid = '0;
            wait_rsp(k, pulses, overlap, ea, eb, ec, ed);
            chk($sformatf("t3.latency%0d", n), 32'(k), 32'd4);
            chk($sformatf("t3.overlap%0d", n), 32'(overlap), 32'd0);
            chk($sformatf("t3.rsp_valid%0d", n), 32'(rsp_valid), 32'(oh));
            chk($sformatf("t3.rsp_q%0d", n), 32'(rsp_q), 32'(q3[n % 4]));
        end

        // Engine never answers: timeout response 64 cycles after WAIT entry
        op("t4", 1, 16'd5, 16'd5, 16'd5, 16'd5, 2, 1'b1, 4'b0010, 16'h0000, 1'b1, 66);
        // 7*-3+4+2 = -15
        op("t4b", 0, 16'd7, 16'hFFFD, 16'd4, 16'hFFFE, 5, 1'b0, 4'b0001, 16'hFFF1, 1'b0, 7);

        // Reset during WAIT
        @(negedge clk);
        stub_mute = 1'b1;
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (4) @(negedge clk);
        chk("t5.busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5.busy", 32'(busy), 32'd0);
        chk("t5.eng_in_val", 32'(eng_in_val), 32'd0);
        chk("t5.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5.eng_a", 32'(eng_a), 32'd0);
        chk("t5.err_stray", 32'(err_stray), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid != '0) seen++;
        end
        chk("t5.no_rsp", 32'(seen), 32'd0);
        stub_mute = 1'b0;
        stub_L = 2;
        req_valid = '1;
        #1;
        chk("t5.grant_after_rst", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_rsp(k, pulses, overlap, ea, eb, ec, ed);
        chk("t5.latency", 32'(k), 32'd4);
        chk("t5.rsp_valid2", 32'(rsp_valid), 32'b0001);
        chk("t5.rsp_q", 32'(rsp_q), 32'hFFF1);

        // Stray out_val while idle
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("t6.err_stray", 32'(err_stray), 32'd1);
        chk("t6.busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid != '0) seen++;
        end
        chk("t6.no_rsp", 32'(seen), 32'd0);
        chk("t6.err_sticky", 32'(err_stray), 32'd1);
        // 100*-1+0-0 = -100
        op("t6b", 2, 16'd100, 16'hFFFF, 16'd0, 16'd0, 1, 1'b0, 4'b0100, 16'hFF9C, 1'b0, 3);
        chk("t6.err_sticky_end", 32'(err_stray), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
